// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared constants for the systolic operand feed controller: word geometry,
// FSM state encodings and a saturating increment used by the performance counters.
package systolic_feed_ctrl_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int DEF_ARRAY_SIZE = 10;
    localparam int WORD_WIDTH     = DATA_WIDTH * DEF_ARRAY_SIZE;

    typedef logic [1:0] feed_state_t;

    localparam feed_state_t FEED_ST_IDLE  = 2'd0;
    localparam feed_state_t FEED_ST_FEED  = 2'd1;
    localparam feed_state_t FEED_ST_DRAIN = 2'd2;
    localparam feed_state_t FEED_ST_DONE  = 2'd3;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Streams N row-buffer words into the systolic skew stage, then flushes it with ARRAY_SIZE-1 zero words.
// Optional stall/cycle counters are built when FEED_PERF_CNT_EN is defined.
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_rows_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [WORD_WIDTH-1:0] sram_data_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  skew_en_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef FEED_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           op_cycles_o
`endif
);

    localparam int DRAIN_W = $clog2(ARRAY_SIZE + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_SIZE - 2);

    feed_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_rows_q, num_rows_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  data_vld_q, data_vld_d;
    logic                  rd_en;
    logic                  drain_step;
    logic                  start_accept;

    always_comb begin
        state_d      = state_q;
        num_rows_d   = num_rows_q;
        rd_cnt_d     = rd_cnt_q;
        base_d       = base_q;
        drain_cnt_d  = drain_cnt_q;
        rd_en        = 1'b0;
        drain_step   = 1'b0;
        start_accept = 1'b0;

        case (state_q)
            FEED_ST_IDLE: begin
                if (start_i) begin
                    start_accept = 1'b1;
                    if (num_rows_i != '0) begin
                        state_d     = FEED_ST_FEED;
                        num_rows_d  = num_rows_i;
                        base_d      = base_addr_i;
                        rd_cnt_d    = '0;
                        drain_cnt_d = '0;
                    end else begin
                        state_d = FEED_ST_DONE;
                    end
                end
            end
            FEED_ST_FEED: begin
                if (!stall_i) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
                    // rd_cnt never exceeds N-1 here, so the +1 cannot wrap
                    if (rd_cnt_q + CNT_WIDTH'(1) == num_rows_q) begin
                        state_d = (ARRAY_SIZE > 1) ? FEED_ST_DRAIN : FEED_ST_DONE;
                    end
                end
            end
            FEED_ST_DRAIN: begin
                // a word still returning from SRAM takes priority over a zero step
                if (!data_vld_q && !stall_i) begin
                    drain_step  = 1'b1;
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = FEED_ST_DONE;
                    end
                end
            end
            FEED_ST_DONE: begin
                state_d = FEED_ST_IDLE;
            end
            default: begin
                state_d = FEED_ST_IDLE;
            end
        endcase

        data_vld_d = rd_en;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FEED_ST_IDLE;
            num_rows_q  <= '0;
            rd_cnt_q    <= '0;
            base_q      <= '0;
            drain_cnt_q <= '0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            rd_cnt_q    <= rd_cnt_d;
            base_q      <= base_d;
            drain_cnt_q <= drain_cnt_d;
            data_vld_q  <= data_vld_d;
        end
    end

    assign rd_en_o   = rd_en;
    assign rd_addr_o = (state_q == FEED_ST_FEED) ? base_q + ADDR_WIDTH'(rd_cnt_q) : '0;
    assign word_o    = data_vld_q ? sram_data_i : '0;
    assign skew_en_o = data_vld_q | drain_step;
    assign busy_o    = (state_q != FEED_ST_IDLE);
    assign done_o    = (state_q == FEED_ST_DONE);

`ifdef FEED_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] op_cycles_q, op_cycles_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        op_cycles_d = op_cycles_q;
        if (start_accept) begin
            stall_cnt_d = '0;
            op_cycles_d = '0;
        end else if (busy_o) begin
            op_cycles_d = sat_inc32(op_cycles_q);
            if (stall_i) begin
                stall_cnt_d = sat_inc32(stall_cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            op_cycles_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            op_cycles_q <= op_cycles_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign op_cycles_o = op_cycles_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized self-checking bench for systolic_feed_ctrl against a cycle-schedule reference model.
module tb_systolic_feed_ctrl;
    import systolic_feed_ctrl_pkg::*;

    localparam int WW   = WORD_WIDTH;
    localparam int AS   = DEF_ARRAY_SIZE;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [7:0]    num_rows_i;
    logic [7:0]    base_addr_i;
    logic          stall_i;
    logic          rd_en_o;
    logic [7:0]    rd_addr_o;
    logic [WW-1:0] sram_data_i;
    logic [WW-1:0] word_o;
    logic          skew_en_o;
    logic          busy_o;
    logic          done_o;
`ifdef FEED_PERF_CNT_EN
    logic [31:0]   stall_cnt_o;
    logic [31:0]   op_cycles_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [WW-1:0] mem [256];
    bit            stall_pat [MAXC];
    bit            e_rd   [MAXC];
    bit            e_skew [MAXC];
    bit            e_done [MAXC];
    bit            e_busy [MAXC];
    logic [7:0]    e_addr [MAXC];
    logic [WW-1:0] e_word [MAXC];
    int            e_stalls;

    systolic_feed_ctrl #(.ARRAY_SIZE(AS), .ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .base_addr_i (base_addr_i),
        .stall_i     (stall_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .sram_data_i (sram_data_i),
        .word_o      (word_o),
        .skew_en_o   (skew_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef FEED_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .op_cycles_o (op_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WW-1:0];
    endfunction

    task automatic clear_stall();
        for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
    endtask

    // Schedule from the rules: reads fill non-stalled cycles, each word lands a cycle later,
    // then ARRAY_SIZE-1 zero steps on free non-stalled cycles, then one done cycle.
    task automatic build_model(input int n, input logic [7:0] base, output int endc);
        int reads, steps, c;
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_skew[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_addr[i] = '0; e_word[i] = '0;
        end
        c = 1;
        if (n != 0) begin
            reads = 0;
            while (reads < n && c < MAXC - 4) begin
                e_busy[c] = 1;
                if (!stall_pat[c]) begin
                    e_rd[c]       = 1;
                    e_addr[c]     = base + 8'(reads);
                    e_skew[c + 1] = 1;
                    e_word[c + 1] = mem[e_addr[c]];
                    reads++;
                end
                c++;
            end
            steps = 0;
            while (steps < AS - 1 && c < MAXC - 4) begin
                e_busy[c] = 1;
                if (!e_skew[c] && !stall_pat[c]) begin
                    e_skew[c] = 1;
                    steps++;
                end
                c++;
            end
        end
        e_done[c] = 1;
        e_busy[c] = 1;
        endc = c;
        e_stalls = 0;
        for (int i = 1; i <= endc; i++) if (stall_pat[i]) e_stalls++;
    endtask

    // Runs one operation started at the next edge; abort_c>0 raises rst_i at the end of that cycle.
    task automatic run_op(input string tag, input int n, input logic [7:0] base,
                          input int pulse_c, input int abort_c);
        int         endc, lim;
        logic       prev_rd;
        logic [7:0] prev_addr;
        build_model(n, base, endc);
        lim         = (abort_c > 0) ? abort_c : endc + 2;
        num_rows_i  = 8'(n);
        base_addr_i = base;
        start_i     = 1'b1;
        stall_i     = 1'b0;
        prev_rd     = 1'b0;
        prev_addr   = '0;
        for (int c = 1; c <= lim; c++) begin
            @(posedge clk); #1;
            sram_data_i = prev_rd ? mem[prev_addr] : rnd_word();
            start_i     = (c == pulse_c);
            if (c == pulse_c) num_rows_i = 8'($urandom_range(1, 200));
            stall_i     = stall_pat[c];
            rst_i       = 1'b0;
            #1;
            n_cmp++;
            if (rd_en_o !== e_rd[c]) begin
                n_bad++; $display("FAIL %s rd_en c%0d: got %b want %b", tag, c, rd_en_o, e_rd[c]);
            end
            if (e_rd[c]) begin
                n_cmp++;
                if (rd_addr_o !== e_addr[c]) begin
                    n_bad++; $display("FAIL %s rd_addr c%0d: got %h want %h", tag, c, rd_addr_o, e_addr[c]);
                end
            end
            n_cmp++;
            if (skew_en_o !== e_skew[c]) begin
                n_bad++; $display("FAIL %s skew_en c%0d: got %b want %b", tag, c, skew_en_o, e_skew[c]);
            end
            n_cmp++;
            if (word_o !== e_word[c]) begin
                n_bad++; $display("FAIL %s word c%0d: got %h want %h", tag, c, word_o, e_word[c]);
            end
            n_cmp++;
            if (done_o !== e_done[c]) begin
                n_bad++; $display("FAIL %s done c%0d: got %b want %b", tag, c, done_o, e_done[c]);
            end
            n_cmp++;
            if (busy_o !== e_busy[c]) begin
                n_bad++; $display("FAIL %s busy c%0d: got %b want %b", tag, c, busy_o, e_busy[c]);
            end
            prev_rd   = rd_en_o;
            prev_addr = rd_addr_o;
            if (c == abort_c) rst_i = 1'b1;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
`ifdef FEED_PERF_CNT_EN
        if (abort_c == 0) begin
            n_cmp++;
            if (stall_cnt_o !== 32'(e_stalls)) begin
                n_bad++; $display("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt_o, e_stalls);
            end
            n_cmp++;
            if (op_cycles_o !== 32'(endc)) begin
                n_bad++; $display("FAIL %s op_cycles: got %0d want %0d", tag, op_cycles_o, endc);
            end
        end
`endif
    endtask

    task automatic check_quiet(input string tag, input int c);
        n_cmp++;
        if ({rd_en_o, skew_en_o, busy_o, done_o} !== 4'b0000) begin
            n_bad++; $display("FAIL %s ctl c%0d: got %b want 0000", tag, c, {rd_en_o, skew_en_o, busy_o, done_o});
        end
        n_cmp++;
        if (word_o !== '0) begin
            n_bad++; $display("FAIL %s word c%0d: got %h want 0", tag, c, word_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; num_rows_i = 8'd3; base_addr_i = 8'h10; stall_i = 1'b0;
        sram_data_i = rnd_word();
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            sram_data_i = rnd_word();
            #1;
            check_quiet("reset", c);
        end
        start_i = 1'b0;
        rst_i   = 1'b0;
        @(posedge clk); #2;
        check_quiet("reset_release", 0);
    endtask

    task automatic test_basic();
        clear_stall();
        run_op("basic_n3", 3, 8'h10, 0, 0);
    endtask

    task automatic test_zero_rows();
        clear_stall();
        run_op("zero_rows", 0, 8'h55, 0, 0);
    endtask

    task automatic test_wrap();
        clear_stall();
        run_op("addr_wrap", 4, 8'hFE, 0, 0);
    endtask

    task automatic test_stall();
        clear_stall();
        for (int i = 2; i <= 4; i++) stall_pat[i] = 1'b1;
        run_op("stall_n2", 2, 8'h20, 0, 0);
    endtask

    task automatic test_start_while_busy();
        clear_stall();
        run_op("start_busy", 6, 8'h40, 3, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            clear_stall();
            for (int i = 1; i < 200; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
            run_op("random", $urandom_range(1, 24), 8'($urandom), (k % 2) ? 3 : 0, 0);
        end
    endtask

    task automatic test_max_rows();
        clear_stall();
        run_op("max_rows", 255, 8'($urandom), 0, 0);
    endtask

    task automatic test_reset_mid_op();
        clear_stall();
        run_op("abort_n5", 5, 8'h80, 0, 6);
        for (int c = 7; c <= 20; c++) begin
            @(posedge clk); #1;
            rst_i       = 1'b0;
            sram_data_i = rnd_word();
            #1;
            check_quiet("abort_after", c);
        end
`ifdef FEED_PERF_CNT_EN
        n_cmp++;
        if ({stall_cnt_o, op_cycles_o} !== 64'd0) begin
            n_bad++; $display("FAIL abort_perf: got %0d/%0d want 0/0", stall_cnt_o, op_cycles_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        clear_stall();
        run_op("fresh_n3", 3, 8'hC0, 0, 0);
        for (int i = 1; i < 60; i++) stall_pat[i] = ($urandom_range(0, 2) == 0);
        run_op("fresh_n7", 7, 8'hFA, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rnd_word();
        clear_stall();
        test_reset();
        test_basic();
        test_zero_rows();
        test_wrap();
        test_stall();
        test_start_while_busy();
        test_random();
        test_max_rows();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
